// File: rtl/conv_encoder_k7.sv
// Rate-1/3 K=7 convolutional encoder (133/171/165), block-buffered,
// tail-biting or zero-tail termination, valid/ready symbol stream.
module conv_encoder_k7 #(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = 11
) (
    input  logic             clk_i,
    input  logic             rst_sync_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             tail_biting_en_i,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    output logic             bit_ready_o,
    output logic [2:0]       code_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic             last_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W:0] MAX_L = (LEN_W + 1)'(MAX_LEN);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ENCODE = 2'd2;
    localparam logic [1:0] S_TAIL   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [5:0]       s_q, s_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             tb_q, tb_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic             buf_q [MAX_LEN];

    logic             rst_w;
    logic             load_en_w;
    logic             len_ok_w;
    logic [AW-1:0]    addr_w;
    logic             u_w;
    logic [LEN_W-1:0] lim_w;

    function automatic logic [2:0] enc_sym(input logic u, input logic [5:0] s);
        logic c0, c1, c2;
        c0 = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
        c1 = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
        c2 = u ^ s[0] ^ s[1] ^ s[3] ^ s[5];
        return {c2, c1, c0};
    endfunction

    assign rst_w     = rst_sync_i | ~en_i;
    assign load_en_w = ~valid_q | code_ready_i;
    assign addr_w    = cnt_q[AW-1:0];
    assign u_w       = (state_q == S_ENCODE) ? buf_q[addr_w] : 1'b0;
    assign lim_w     = (state_q == S_TAIL) ? LEN_W'(6) : len_q;

    // Tail-biting needs at least 6 bits so the loaded register is the block tail.
    assign len_ok_w = (len_i != '0)
                    && ({1'b0, len_i} <= MAX_L)
                    && !(tail_biting_en_i && (len_i < LEN_W'(6)));

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        tb_d    = tb_q;
        code_d  = code_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (start_i) begin
                    if (len_ok_w) begin
                        state_d = S_LOAD;
                        cnt_d   = '0;
                        s_d     = '0;
                        len_d   = len_i;
                        tb_d    = tail_biting_en_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bit_valid_i) begin
                    s_d   = {s_q[4:0], bit_i};
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_ENCODE;
                        cnt_d   = '0;
                        if (!tb_q) begin
                            s_d = '0;
                        end
                    end
                end
            end
            S_ENCODE, S_TAIL: begin
                if (load_en_w) begin
                    if (valid_q && last_q) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                    end else if (cnt_q != lim_w) begin
                        code_d  = enc_sym(u_w, s_q);
                        valid_d = 1'b1;
                        s_d     = {s_q[4:0], u_w};
                        cnt_d   = cnt_q + LEN_W'(1);
                        if (cnt_q == lim_w - LEN_W'(1)) begin
                            if ((state_q == S_TAIL) || tb_q) begin
                                last_d = 1'b1;
                            end else begin
                                state_d = S_TAIL;
                                cnt_d   = '0;
                            end
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_w) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            tb_q    <= 1'b0;
            code_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tb_q    <= tb_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // Block buffer: no reset, only meaningful between LOAD and ENCODE.
    always_ff @(posedge clk_i) begin
        if ((state_q == S_LOAD) && bit_valid_i) begin
            buf_q[addr_w] <= bit_i;
        end
    end

    assign bit_ready_o  = (state_q == S_LOAD);
    assign busy_o       = (state_q != S_IDLE);
    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign last_o       = last_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Bench for conv_encoder_k7: convolution-sum reference model,
// random blocks, backpressure, rejects and mid-block reset.
module tb_conv_encoder_k7;

    localparam int MAX_LEN = 1024;
    localparam int LEN_W   = 11;

    logic             clk_i = 1'b0;
    logic             rst_sync_i;
    logic             en_i;
    logic             start_i;
    logic [LEN_W-1:0] len_i;
    logic             tail_biting_en_i;
    logic             bit_i;
    logic             bit_valid_i;
    logic             bit_ready_o;
    logic [2:0]       code_o;
    logic             code_valid_o;
    logic             code_ready_i;
    logic             last_o;
    logic             busy_o;
    logic             err_o;

    conv_encoder_k7 #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk_i(clk_i),
        .rst_sync_i(rst_sync_i),
        .en_i(en_i),
        .start_i(start_i),
        .len_i(len_i),
        .tail_biting_en_i(tail_biting_en_i),
        .bit_i(bit_i),
        .bit_valid_i(bit_valid_i),
        .bit_ready_o(bit_ready_o),
        .code_o(code_o),
        .code_valid_o(code_valid_o),
        .code_ready_i(code_ready_i),
        .last_o(last_o),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    bit          bits [0:MAX_LEN-1];
    logic [3:0]  exp_q [$];
    logic [3:0]  got_q [$];
    logic [3:0]  ref_q [$];
    bit          mon_en = 1'b0;
    bit          bp_en  = 1'b0;

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_l = 1'b0;
    logic [2:0]  prev_c = '0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [6:0] gen(input int j);
        case (j)
            0: return 7'o133;
            1: return 7'o171;
            default: return 7'o165;
        endcase
    endfunction

    // Literal written as c0c1c2 -> code_o bit order {c2,c1,c0}
    function automatic logic [2:0] rev3(input logic [2:0] l);
        return {l[0], l[1], l[2]};
    endfunction

    // c_j[t] = XOR_k g_j(delay k) & x[t-k]; x circular (tail-biting)
    // or zero outside 0..K-1 (zero-tail, K+6 outputs).
    function automatic void build_exp(input int K, input bit tbm);
        int n;
        int idx;
        bit x;
        logic [6:0] g;
        logic [2:0] c;
        n = tbm ? K : K + 6;
        exp_q.delete();
        for (int t = 0; t < n; t++) begin
            c = '0;
            for (int j = 0; j < 3; j++) begin
                g = gen(j);
                for (int k = 0; k < 7; k++) begin
                    idx = t - k;
                    if (tbm) x = bits[((idx % K) + K) % K];
                    else x = (idx >= 0 && idx < K) ? bits[idx] : 1'b0;
                    c[j] = c[j] ^ (g[6-k] & x);
                end
            end
            exp_q.push_back({(t == n - 1), c});
        end
    endfunction

    always @(posedge clk_i) begin
        #1;
        code_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk_i) begin
        logic [3:0] e;
        if (mon_en && !rst_sync_i && en_i) begin
            if (prev_v && !prev_r) begin
                check("stall_hold", {code_valid_o, last_o, code_o},
                      {1'b1, prev_l, prev_c});
            end
            if (code_valid_o && code_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_symbol", {last_o, code_o}, 32'hdead);
                end else begin
                    e = exp_q.pop_front();
                    check("symbol", {last_o, code_o}, e);
                    got_q.push_back({last_o, code_o});
                end
            end
        end
        prev_v = code_valid_o;
        prev_r = code_ready_i;
        prev_l = last_o;
        prev_c = code_o;
    end

    task automatic do_start(input int K, input bit tbm);
        start_i = 1'b1;
        len_i = LEN_W'(K);
        tail_biting_en_i = tbm;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("ready_after_start", bit_ready_o, 1);
    endtask

    task automatic load_bits(input int K, input bit hold_start);
        for (int i = 0; i < K; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                bit_valid_i = 1'b0;
                @(posedge clk_i); #1;
            end
            if (hold_start) begin
                start_i = 1'b1;
                len_i = '0;
            end
            bit_valid_i = 1'b1;
            bit_i = bits[i];
            if (bit_ready_o !== 1'b1) check("bit_ready_load", bit_ready_o, 1);
            @(posedge clk_i); #1;
        end
        bit_valid_i = 1'b0;
        start_i = 1'b0;
    endtask

    task automatic run_block(input int K, input bit tbm, input bit hold_start);
        int cyc;
        build_exp(K, tbm);
        got_q.delete();
        do_start(K, tbm);
        load_bits(K, hold_start);
        check("bit_ready_after_load", bit_ready_o, 0);
        check("valid_latency_lo", code_valid_o, 0);
        if (hold_start) check("err_ignored_busy", err_o, 0);
        @(posedge clk_i); #1;
        check("valid_latency_hi", code_valid_o, 1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 8 * K + 200) begin
            @(posedge clk_i);
            cyc++;
        end
        check("drain_timeout", exp_q.size(), 0);
        #1;
        check("busy_after_last", busy_o, 0);
        check("valid_after_last", code_valid_o, 0);
    endtask

    task automatic do_reject(input int K, input bit tbm);
        start_i = 1'b1;
        len_i = LEN_W'(K);
        tail_biting_en_i = tbm;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("reject_err", err_o, 1);
        check("reject_busy", busy_o, 0);
        check("reject_ready", bit_ready_o, 0);
        @(posedge clk_i); #1;
        check("reject_err_pulse", err_o, 0);
    endtask

    task automatic abort_run(input bit use_en);
        mon_en = 1'b0;
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        do_start(40, 1'b0);
        load_bits(40, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        if (use_en) en_i = 1'b0;
        else rst_sync_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort_outs", {code_o, code_valid_o, last_o, bit_ready_o,
                             busy_o, err_o}, 0);
        en_i = 1'b1;
        rst_sync_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort_idle", {code_valid_o, busy_o}, 0);
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        logic [2:0] lit [7];
        logic [3:0] e;
        rst_sync_i = 1'b1;
        en_i = 1'b1;
        start_i = 1'b0;
        len_i = '0;
        tail_biting_en_i = 1'b0;
        bit_i = 1'b0;
        bit_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outs", {code_o, code_valid_o, last_o, bit_ready_o,
                             busy_o, err_o}, 0);
        rst_sync_i = 1'b0;
        @(posedge clk_i); #1;
        mon_en = 1'b1;

        // Model pins: impulse response, zero-tail K=1
        lit = '{3'b111, 3'b011, 3'b111, 3'b110, 3'b001, 3'b100, 3'b111};
        bits[0] = 1'b1;
        build_exp(1, 1'b0);
        check("pin_zt_len", exp_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            e = exp_q[i];
            check("pin_zt_sym", e, {(i == 6), rev3(lit[i])});
        end
        run_block(1, 1'b0, 1'b0);

        // Tail-biting K=8 impulse
        for (int i = 0; i < 8; i++) bits[i] = (i == 0);
        build_exp(8, 1'b1);
        e = exp_q[7];
        check("pin_tb8_last", e, {1'b1, 3'b000});
        e = exp_q[3];
        check("pin_tb8_s3", e, {1'b0, rev3(3'b110)});
        run_block(8, 1'b1, 1'b1);

        // Tail-biting K=6, impulse at end wraps into start
        for (int i = 0; i < 6; i++) bits[i] = (i == 5);
        build_exp(6, 1'b1);
        e = exp_q[0];
        check("pin_tb6_first", e, {1'b0, rev3(3'b011)});
        run_block(6, 1'b1, 1'b0);

        // Random K=40 both modes, with and without backpressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
            bp_en = r[1];
            run_block(40, r[0], 1'b0);
        end
        bp_en = 1'b0;

        // Random lengths
        for (int r = 0; r < 4; r++) begin
            int k;
            k = $urandom_range(6, 70);
            for (int i = 0; i < k; i++) bits[i] = 1'($urandom_range(0, 1));
            bp_en = 1'b1;
            run_block(k, r[0], 1'b0);
        end

        // Backpressure must not change the symbol stream
        for (int i = 0; i < 40; i++) bits[i] = 1'($urandom_range(0, 1));
        bp_en = 1'b0;
        run_block(40, 1'b0, 1'b0);
        ref_q = got_q;
        bp_en = 1'b1;
        run_block(40, 1'b0, 1'b0);
        bp_en = 1'b0;
        check("bp_count", got_q.size(), 46);
        if (got_q.size() == ref_q.size()) begin
            for (int i = 0; i < got_q.size(); i++) begin
                check("bp_same", got_q[i], ref_q[i]);
            end
        end

        do_reject(0, 1'b0);
        do_reject(MAX_LEN + 1, 1'b0);
        do_reject(5, 1'b1);

        abort_run(1'b0);
        for (int i = 0; i < 8; i++) bits[i] = 1'($urandom_range(0, 1));
        run_block(8, 1'b1, 1'b0);
        abort_run(1'b1);
        for (int i = 0; i < 8; i++) bits[i] = 1'($urandom_range(0, 1));
        run_block(8, 1'b0, 1'b0);

        repeat (2) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_encoder_k7.md
# conv_encoder_k7

Rate-1/3, constraint-length-7 convolutional encoder that produces the coded stream our Viterbi decoder consumes: generators 133/171/165 (octal), tail-biting or zero-tail termination. It buffers one input block (needed for the tail-biting initial state), then emits one 3-bit coded symbol per input bit over a valid/ready stream. It is the transmit-side counterpart of the ACS/traceback decoder chain and serves as its loopback stimulus source.

## Interface
- MAX_LEN, 1024: maximum block length K in bits (buffer depth)
- LEN_W, 11: width of len_i; must hold MAX_LEN
- clk_i  in  1  clock
- rst_sync_i  in  1  synchronous, active-high reset
- en_i  in  1  enable; low acts exactly as rst_sync_i
- start_i  in  1  block start request, sampled only in IDLE
- len_i  in  LEN_W  block length K, sampled with start_i
- tail_biting_en_i  in  1  1 = tail-biting, 0 = zero-tail; sampled with start_i
- bit_i  in  1  info bit
- bit_valid_i  in  1  info bit valid
- bit_ready_o  out  1  encoder accepts info bit
- code_o  out  3  coded symbol; code_o[j] = c_j
- code_valid_o  out  1  code_o valid
- code_ready_i  in  1  downstream accepts symbol
- last_o  out  1  marks final symbol of block (qualified by code_valid_o)
- busy_o  out  1  block in progress
- err_o  out  1  one-cycle pulse: start_i rejected

## Operation
- States: IDLE, LOAD, ENCODE, TAIL.
- IDLE: bit_ready_o=0, busy_o=0. start_i with valid len -> LOAD, in-count=0, shift register s cleared. Invalid: len_i=0, len_i>MAX_LEN, or tail-biting with len_i<6 -> err_o pulse next cycle, stay IDLE.
- LOAD: bit_ready_o=1. Each bit_valid_i&bit_ready_o writes buffer[cnt], cnt++, and shifts s <= {s[4:0], bit_i} (s[0] newest). Accepting bit K-1 -> ENCODE, bit_ready_o=0 from the next cycle.
- Entering ENCODE: tail-biting keeps s (s[i]=d[K-1-i], i=0..5); zero-tail clears s to 0. Read index=0.
- Encode step (u = input bit): c0 = u^s1^s2^s4^s5 (133); c1 = u^s0^s1^s2^s5 (171); c2 = u^s0^s1^s3^s5 (165). Then s <= {s[4:0], u}, index++.
- ENCODE: u=buffer[index]. After index K-1: tail-biting -> that symbol carries last_o; zero-tail -> TAIL.
- TAIL: 6 steps with u=0; 6th symbol carries last_o.
- Symbols per block: K (tail-biting), K+6 (zero-tail). Tail-biting final s equals initial s.
- Final handshake (code_valid_o&code_ready_i&last_o) -> IDLE.
- Buffer has combinational read, no reset; contents irrelevant outside LOAD/ENCODE.

## Timing
- Reset (rst_sync_i=1 or en_i=0 at a clock edge): state IDLE, s=0, counters 0; all outputs 0 (code_o=000, code_valid_o=0, last_o=0, bit_ready_o=0, busy_o=0, err_o=0). Applies mid-block: block abandoned, no last_o emitted.
- busy_o: 1 from cycle after start accepted through the cycle of the final handshake; 0 the next cycle.
- start_i while busy_o=1: ignored, no err_o.
- bit_ready_o rises the cycle after start accepted.
- Last info bit accepted at edge N -> code_valid_o first high after edge N+1.
- code_o/code_valid_o/last_o are registers; load a new symbol when !code_valid_o | code_ready_i. With code_valid_o=1 & code_ready_i=0, code_o, last_o, s and index hold.
- Throughput: 1 symbol/cycle with code_ready_i held high; no bubbles between ENCODE and TAIL.
- Back-to-back: start_i accepted earliest the cycle after busy_o falls.

## Test plan
- Zero-tail, K=1, bit 1 -> 7 symbols (c0c1c2): 111, 011, 111, 110, 001, 100, 111; last_o only on the 7th; busy_o low after.
- Tail-biting, K=8, bits 1,0,0,0,0,0,0,0 -> initial s=0; symbols 111, 011, 111, 110, 001, 100, 111, 000; last_o on 8th.
- Tail-biting, K=6, bits 0,0,0,0,0,1 -> initial s0=1; first symbol 011; sequence is impulse response wrapped circularly; compare to bit-exact model, also for random K=40 blocks both modes.
- Backpressure: random code_ready_i (50%) on K=40 zero-tail -> 46 symbols, identical to ready-always-high run, code_o stable while stalled.
- Rejects: len_i=0, len_i=MAX_LEN+1, tail-biting len_i=5 -> err_o one-cycle pulse, busy_o=0, bit_ready_o=0.
- rst_sync_i (then en_i=0) asserted mid-ENCODE of K=40 -> all outputs 0 next cycle; following K=8 block encodes correctly.
